// File: rtl/multi_byte_alu_seq_if.sv
// Control-side bundle for the byte-serial multi-precision ALU.
// Handshake: start is sampled only while busy=0; an accepted start raises busy on the next
// cycle, done pulses for one cycle as result/flags become valid, and busy falls after done.
interface multi_byte_alu_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 4,
  parameter int LEN_W      = $clog2(MAX_BYTES + 1)
);
  logic                              start;
  logic [1:0]                        op;
  logic [LEN_W-1:0]                  len;
  logic                              carry_in;
  logic [DATA_WIDTH*MAX_BYTES-1:0]   operand_a;
  logic [DATA_WIDTH*MAX_BYTES-1:0]   operand_b;
  logic                              busy;
  logic                              done;
  logic                              error;
  logic [DATA_WIDTH*MAX_BYTES-1:0]   result;
  logic                              flag_zero;
  logic                              flag_negative;
  logic                              flag_carry;
  logic                              flag_overflow;

  modport master (
    output start, op, len, carry_in, operand_a, operand_b,
    input  busy, done, error, result, flag_zero, flag_negative, flag_carry, flag_overflow
  );

  modport slave (
    input  start, op, len, carry_in, operand_a, operand_b,
    output busy, done, error, result, flag_zero, flag_negative, flag_carry, flag_overflow
  );
endinterface

// File: rtl/multi_byte_alu_seq.sv
// Byte-serial ADD/ADC/SUB/SBC engine: one DATA_WIDTH beat per clock, LSB first, carry chained,
// with Z/N/C/V covering the whole active operand length.
module multi_byte_alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 4,
  parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_byte_alu_seq_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int               TOTAL_W = DATA_WIDTH * MAX_BYTES;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  logic                 sub_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     idx;
  logic [TOTAL_W-1:0]   a_q;
  logic [TOTAL_W-1:0]   b_q;
  logic [TOTAL_W-1:0]   acc;
  logic                 carry_q;
  logic                 zero_q;

  logic [DATA_WIDTH-1:0] a_beat;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum;
  logic [TOTAL_W-1:0]    acc_next;
  logic                  last_beat;
  logic                  beat_zero;
  logic                  len_ok;

  assign dbg_state = state;
  assign len_ok    = (bus.len != '0) && (bus.len <= MAX_LEN);

  // Subtraction is a + ~b + carry, so the same adder serves all four ops.
  always_comb begin
    a_beat    = a_q[idx*DATA_WIDTH +: DATA_WIDTH];
    b_eff     = b_q[idx*DATA_WIDTH +: DATA_WIDTH] ^ {DATA_WIDTH{sub_q}};
    sum       = {1'b0, a_beat} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, carry_q};
    acc_next  = acc;
    acc_next[idx*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
    last_beat = (idx == len_q - LEN_W'(1));
    beat_zero = (sum[DATA_WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      sub_q             <= 1'b0;
      len_q             <= '0;
      idx               <= '0;
      a_q               <= '0;
      b_q               <= '0;
      acc               <= '0;
      carry_q           <= 1'b0;
      zero_q            <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.error         <= 1'b0;
      bus.result        <= '0;
      bus.flag_zero     <= 1'b0;
      bus.flag_negative <= 1'b0;
      bus.flag_carry    <= 1'b0;
      bus.flag_overflow <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              sub_q    <= bus.op[1];
              len_q    <= bus.len;
              a_q      <= bus.operand_a;
              b_q      <= bus.operand_b;
              // ADD=0, ADC=carry_in, SUB=1 (no borrow), SBC=carry_in
              carry_q  <= bus.op[0] ? bus.carry_in : bus.op[1];
              acc      <= '0;
              idx      <= '0;
              zero_q   <= 1'b1;
              bus.busy <= 1'b1;
              state    <= S_RUN;
            end else begin
              bus.error <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc     <= acc_next;
          carry_q <= sum[DATA_WIDTH];
          zero_q  <= zero_q & beat_zero;
          if (last_beat) begin
            // Final beat: publish result and flags together with done.
            bus.result        <= acc_next;
            bus.flag_zero     <= zero_q & beat_zero;
            bus.flag_negative <= sum[DATA_WIDTH-1];
            bus.flag_carry    <= sum[DATA_WIDTH];
            bus.flag_overflow <= (a_beat[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                                 (sum[DATA_WIDTH-1] != a_beat[DATA_WIDTH-1]);
            bus.done          <= 1'b1;
            state             <= S_DONE;
          end else begin
            idx <= idx + LEN_W'(1);
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_byte_alu_seq.sv
// Self-checking bench for multi_byte_alu_seq: whole-word arithmetic model plus literal pins.
module tb_multi_byte_alu_seq;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int LW = $clog2(MB + 1);
  localparam int TW = DW * MB;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;
  multi_byte_alu_seq_if #(.DATA_WIDTH(DW), .MAX_BYTES(MB), .LEN_W(LW)) bus ();
  multi_byte_alu_seq #(.DATA_WIDTH(DW), .MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [TW+3:0] exp_q[$];
  logic [TW+3:0] cur_exp;
  logic [TW+3:0] dut_o;
  assign dut_o = {bus.flag_zero, bus.flag_negative, bus.flag_carry, bus.flag_overflow, bus.result};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: treat the active length as one wide integer; returns {Z,N,C,V,result}.
  function automatic logic [TW+3:0] model(input logic [1:0] op, input int len, input logic cin,
                                          input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [63:0] mask, am, bm, full, r;
    logic c0;
    int top;
    mask = (64'd1 << (DW * len)) - 64'd1;
    am   = {32'd0, a} & mask;
    bm   = op[1] ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    c0   = op[0] ? cin : op[1];
    full = am + bm + {63'd0, c0};
    r    = full & mask;
    top  = DW * len - 1;
    return {(r == 64'd0), r[top], full[DW*len],
            (am[top] == bm[top]) && (r[top] != am[top]), r[TW-1:0]};
  endfunction

  // scoreboard: every cycle the held outputs must equal the last completed operation
  initial begin
    cur_exp = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_exp = '0;
        exp_q.delete();
      end else begin
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got done=1 want no pending op at %0t", $time);
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end
        chk("outputs", dut_o, cur_exp);
      end
    end
  end

  // driver
  task automatic run_op(input logic [1:0] op, input int len, input logic cin,
                        input logic [TW-1:0] a, input logic [TW-1:0] b, input bit restart);
    bit legal;
    legal = (len >= 1) && (len <= MB);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.len       = LW'(len);
    bus.carry_in  = cin;
    bus.operand_a = a;
    bus.operand_b = b;
    if (legal) exp_q.push_back(model(op, len, cin, a, b));
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.op        = 2'($urandom_range(0, 3));
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    if (!legal) begin
      chk("err_pulse", bus.error, 1);
      chk("err_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      chk("err_clear", bus.error, 0);
      chk("err_busy2", bus.busy, 0);
      chk("err_nodone", bus.done, 0);
    end else begin
      for (int c = 1; c <= len + 1; c++) begin
        if (c > 1) begin
          @(posedge clk);
          #1;
        end
        if (restart && c == 1) begin
          bus.start     = 1'b1;
          bus.len       = LW'($urandom_range(1, MB));
          bus.carry_in  = 1'($urandom_range(0, 1));
          bus.operand_a = $urandom;
          bus.operand_b = $urandom;
        end
        if (restart && c == 2) bus.start = 1'b0;
        chk("busy", bus.busy, 1);
        chk("done_timing", bus.done, (c == len + 1));
      end
      @(posedge clk);
      #1;
      chk("busy_low", bus.busy, 0);
      chk("done_low", bus.done, 0);
    end
  endtask

  task automatic lit(input string name, input logic [1:0] op, input int len, input logic cin,
                     input logic [TW-1:0] a, input logic [TW-1:0] b, input bit restart,
                     input logic [TW+3:0] want);
    run_op(op, len, cin, a, b, restart);
    chk({name, "_model"}, model(op, len, cin, a, b), want);
    chk({name, "_dut"}, dut_o, want);
  endtask

  initial begin
    int len;
    int il;
    bus.start     = 1'b0;
    bus.op        = 2'd0;
    bus.len       = '0;
    bus.carry_in  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_outputs", dut_o, 0);
    @(negedge clk);
    reset = 1'b1;

    lit("add_ff_01",  2'b00, 1, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 36'hA_0000_0000);
    lit("add_chain",  2'b00, 2, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 36'h0_0000_0100);
    lit("add_ovf",    2'b00, 1, 1'b0, 32'h0000_007F, 32'h0000_0001, 1'b0, 36'h5_0000_0080);
    lit("sub_borrow", 2'b10, 4, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, 36'h4_FFFF_FFFF);
    lit("sbc_nb",     2'b11, 2, 1'b1, 32'h0000_1234, 32'h0000_0034, 1'b0, 36'h2_0000_1200);
    lit("adc_restart",2'b01, 2, 1'b1, 32'h0000_1234, 32'h0000_0000, 1'b1, 36'h0_0000_1235);
    run_op(2'b00, 0, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    chk("len0_keeps", dut_o, 36'h0_0000_1235);
    lit("len3_stale", 2'b00, 3, 1'b0, 32'hAB00_0001, 32'hCD00_0002, 1'b0, 36'h0_0000_0003);
    chk("len3_top_zero", bus.result[31:24], 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        il  = $urandom_range(0, 3);
        len = (il == 0) ? 0 : il + 4;
      end else begin
        len = $urandom_range(1, MB);
      end
      run_op(2'($urandom_range(0, 3)), len, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0) ? '1 : TW'($urandom),
             ($urandom_range(0, 4) == 0) ? '0 : TW'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    // reset in the middle of a len=4 ADD
    run_op(2'b00, 1, 1'b0, 32'h0000_00F0, 32'h0000_0020, 1'b0);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = 2'b00;
    bus.len       = LW'(4);
    bus.operand_a = 32'h89AB_CDEF;
    bus.operand_b = 32'h1234_5678;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_outputs", dut_o, 0);
    @(negedge clk);
    reset = 1'b1;
    lit("post_rst", 2'b00, 1, 1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0, 36'h0_0000_0030);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_byte_alu_seq.md
Name: multi_byte_alu_seq

Overview:
Byte-serial multi-precision arithmetic engine for the SAP-2 datapath. It generalises the single-byte ADD B path to ADD, ADC, SUB and SBC over operands of 1..MAX_BYTES beats of DATA_WIDTH bits. Beats are processed LSB first, one per clock, with the carry chained between beats. It sits beside the CPU ALU and is started and finished by the control unit through a start/busy/done handshake. It returns the full result plus Z/N/C/V flags covering the whole operand length.

Parameters:
DATA_WIDTH, 8, bits per beat; matches arch_defs_pkg DATA_WIDTH.
MAX_BYTES, 4, maximum operand length in beats; must be >= 1.
LEN_W, $clog2(MAX_BYTES+1), width of the len port.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request an operation; sampled only in IDLE.
op  input  2  operation: 00=ADD, 01=ADC, 10=SUB, 11=SBC.
len  input  LEN_W  number of active beats, valid range 1..MAX_BYTES.
carry_in  input  1  carry for ADC; no-borrow flag for SBC (1 = no borrow).
operand_a  input  DATA_WIDTH*MAX_BYTES  minuend/augend, beat 0 in the LSBs.
operand_b  input  DATA_WIDTH*MAX_BYTES  subtrahend/addend.
busy  output  1  high while in RUN or DONE.
done  output  1  one-cycle pulse when the result and flags become valid.
error  output  1  one-cycle pulse when len is illegal (0 or > MAX_BYTES).
result  output  DATA_WIDTH*MAX_BYTES  result; beats at index >= len are zero.
flag_zero  output  1  Z: all active result beats are zero.
flag_negative  output  1  N: MSB of result beat len-1.
flag_carry  output  1  C: carry out of the top active beat; for SUB/SBC, 1 = no borrow.
flag_overflow  output  1  V: signed overflow of the top active beat.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy, done and error = 0; result = 0; all four flags = 0. Reset asserted mid-operation aborts immediately with the same values; no partial result is kept.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1, len legal:
  - Latch op, len, operand_a and operand_b.
  - Initial carry: ADD=0, ADC=carry_in, SUB=1, SBC=carry_in.
  - Clear the result register and the beat index; go to RUN.
- IDLE, start=1, len illegal: pulse error for one cycle. Stay in IDLE; result and flags are unchanged.
- RUN, one beat per cycle at index i:
  - Sum = a[i] + (sub ? ~b[i] : b[i]) + carry, computed DATA_WIDTH+1 wide.
  - Store the low DATA_WIDTH bits into result beat i; the next carry is the top bit.
  - Z accumulates as the AND of (beat==0) across active beats.
  - After beat len-1, go to DONE.
- DONE: one cycle with done=1. Flags update in that same cycle:
  - N = MSB of the top active beat.
  - C = final carry.
  - V = (a_msb == b'_msb) && (r_msb != a_msb), where b' is the inverted b for SUB/SBC.
  - Then return to IDLE.
- Latency: start accepted at edge T. done is high in cycle T+len+1, and busy is high from T+1 through T+len+1.
- result and flags hold their values after done until the next accepted start. They are not updated while in RUN; the result register is internal until DONE.
- start while busy is ignored and not queued. start is accepted again in the cycle after done.
- Operand and op inputs may change freely after the accepting edge.
- len == MAX_BYTES: the top beat is the last physical beat; no wrap of the beat index.

Test Plan:
- ADD, len=1, 0xFF+0x01 -> result 0x00, Z=1, N=0, C=1, V=0; done exactly 2 cycles after the start edge.
- ADD, len=2, 0x00FF+0x0001 -> 0x0100, Z=0, N=0, C=0, V=0 (carry chained between beats); ADD, len=1, 0x7F+0x01 -> 0x80, N=1, V=1, C=0.
- SUB, len=4, 0x00000000-0x00000001 -> 0xFFFFFFFF, N=1, C=0 (borrow), V=0, Z=0; SBC, len=2, carry_in=1, 0x1234-0x0034 -> 0x1200, C=1.
- ADC, len=2, carry_in=1, 0x1234+0x0000 -> 0x1235. start re-pulsed during RUN with different operands is ignored; the first result is reported.
- Illegal length: len=0 -> error pulse, busy stays 0, no done. len=3 with stale upper operand bits -> result bits [31:24] = 0.
- Reset during RUN of a len=4 ADD -> busy, done, result and flags = 0 immediately. The next start with len=1, 0x10+0x20 -> 0x30, Z=0, N=0, C=0.
